// File: rtl/debug_scan_ctrl.sv
// Avalon-MM debug register scanner: walks sel_out over [first..last] and captures dbg_data into a 32-entry buffer.
// Define DEBUG_SCAN_IRQ_EN to build the scan-complete interrupt (CTRL bit20 enable flop).
module debug_scan_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [31:0] dbg_data,
    output logic [4:0]  sel_out,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cur, cur_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [4:0]  last_r;
    logic [3:0]  settle_r;
    logic        done, err;
    logic [4:0]  manual_sel;
    logic [4:0]  rd_index;
    logic [31:0] cap_buf [32];

    logic wr_en, rd_en, ctrl_wr, status_wr;
    logic abort_req, start_req, start_ok, start_bad, capture_last;
    logic unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & ~read_n;
    assign ctrl_wr      = wr_en & (address == 3'd0);
    assign status_wr    = wr_en & (address == 3'd1);
    assign abort_req    = ctrl_wr & writedata[1];
    assign start_req    = ctrl_wr & writedata[0] & ~writedata[1] & (state == IDLE);
    assign start_ok     = start_req & (writedata[9:5] <= writedata[14:10]);
    assign start_bad    = start_req & ~start_ok;
    assign capture_last = (state == CAPTURE) & (cur == last_r) & ~abort_req;
    assign unused_wdata = ^{writedata[31:20], writedata[15], writedata[4:2]};

    assign busy    = (state != IDLE);
    assign sel_out = busy ? cur : manual_sel;

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        cnt_nxt   = cnt;
        if (abort_req) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state_nxt = SETTLE;
                        cur_nxt   = writedata[9:5];
                        cnt_nxt   = writedata[19:16];
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        state_nxt = CAPTURE;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    if (cur == last_r) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SETTLE;
                        cur_nxt   = cur + 5'd1;
                        cnt_nxt   = settle_r;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur      <= 5'd0;
            cnt      <= 4'd0;
            last_r   <= 5'd0;
            settle_r <= 4'd0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            cnt   <= cnt_nxt;
            if (start_ok) begin
                last_r   <= writedata[14:10];
                settle_r <= writedata[19:16];
            end
        end
    end

    // Setting a status bit beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (start_ok) begin
                done <= 1'b0;
            end else if (capture_last) begin
                done <= 1'b1;
            end else if (status_wr && writedata[1]) begin
                done <= 1'b0;
            end
            if (start_bad) begin
                err <= 1'b1;
            end else if (status_wr && writedata[2]) begin
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            manual_sel <= 5'd0;
            rd_index   <= 5'd0;
        end else begin
            if (wr_en && address == 3'd2) begin
                manual_sel <= writedata[4:0];
            end
            if (wr_en && address == 3'd3) begin
                rd_index <= writedata[4:0];
            end else if (rd_en && address == 3'd4) begin
                rd_index <= rd_index + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE && !abort_req) begin
            cap_buf[cur] <= dbg_data;
        end
    end

`ifdef DEBUG_SCAN_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
        end else if (ctrl_wr && state == IDLE) begin
            irq_en <= writedata[20];
        end
    end

    assign irq = done & irq_en;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd1:    readdata = {29'd0, err, done, busy};
            3'd2:    readdata = {27'd0, manual_sel};
            3'd3:    readdata = {27'd0, rd_index};
            3'd4:    readdata = cap_buf[rd_index];
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Self-checking bench for debug_scan_ctrl: scan-level behavioural model plus directed literal checks.
module tb_debug_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [31:0] dbg_data;
    logic [4:0]  sel_out;
    logic        busy;
    logic        irq;

`ifdef DEBUG_SCAN_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    debug_scan_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .dbg_data   (dbg_data),
        .sel_out    (sel_out),
        .busy       (busy),
        .irq        (irq)
    );

    assign dbg_data = 32'hA0 + {27'd0, sel_out};

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Scan model: position in a scan is just elapsed cycles divided by (S+2).
    bit          m_active;
    int          m_elapsed, m_first, m_last, m_s;
    bit          m_done, m_err, m_irq_en;
    int          m_manual, m_rd_index;
    logic [31:0] m_buf [32];
    bit          m_valid [32];

    int exp_seq [9] = '{2, 2, 2, 3, 3, 3, 4, 4, 4};

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_elapsed = 0; m_first = 0; m_last = 0; m_s = 0;
        m_done = 0; m_err = 0; m_irq_en = 0; m_manual = 0; m_rd_index = 0;
        for (int i = 0; i < 32; i++) m_valid[i] = 0;
    endtask

    task automatic model_step();
        bit          wr, rd, was_active, set_done;
        int          a, per, idx, f, l;
        logic [31:0] d;
        wr = chipselect && !write_n;
        rd = chipselect && !read_n;
        a = int'(address);
        d = writedata;
        was_active = m_active;
        set_done = 0;
        if (wr && a == 0 && d[1]) begin
            m_active = 0;
        end else if (m_active) begin
            per = m_s + 2;
            idx = m_first + m_elapsed / per;
            if (m_elapsed % per == per - 1) begin
                m_buf[idx] = 32'hA0 + 32'(idx);
                m_valid[idx] = 1;
                if (idx == m_last) begin
                    m_active = 0;
                    m_done = 1;
                    set_done = 1;
                end
            end
            if (m_active) m_elapsed++;
        end
        if (wr && a == 0 && !was_active) begin
            if (IRQ_BUILD) m_irq_en = d[20];
            if (d[0] && !d[1]) begin
                f = int'(d[9:5]);
                l = int'(d[14:10]);
                if (f <= l) begin
                    m_active = 1; m_elapsed = 0; m_first = f; m_last = l;
                    m_s = int'(d[19:16]); m_done = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
        if (wr && a == 1) begin
            if (d[1] && !set_done) m_done = 0;
            if (d[2]) m_err = 0;
        end
        if (wr && a == 2) m_manual = int'(d[4:0]);
        if (wr && a == 3) m_rd_index = int'(d[4:0]);
        else if (rd && a == 4) m_rd_index = (m_rd_index + 1) % 32;
    endtask

    function automatic bit exp_rdata(input int a, output logic [31:0] v);
        v = 32'd0;
        case (a)
            1: v = {29'd0, m_err, m_done, m_active};
            2: v = 32'(m_manual);
            3: v = 32'(m_rd_index);
            4: begin
                if (!m_valid[m_rd_index]) return 0;
                v = m_buf[m_rd_index];
            end
            default: v = 32'd0;
        endcase
        return 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset_n) model_step();
        end
    end

    initial begin : compare_proc
        logic [31:0] ev;
        int          es;
        forever begin
            @(negedge clk);
            es = m_active ? (m_first + m_elapsed / (m_s + 2)) : m_manual;
            check_output("busy", {31'd0, busy}, {31'd0, m_active});
            check_output("sel_out", {27'd0, sel_out}, 32'(es));
            check_output("irq", {31'd0, irq}, {31'd0, IRQ_BUILD & m_done & m_irq_en});
            if (exp_rdata(int'(address), ev)) check_output("readdata", readdata, ev);
        end
    end

    task automatic apply_stimulus(input logic cs, input logic wn, input logic rn,
                                  input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        read_n     = rn;
        address    = a;
        writedata  = d;
    endtask

    task automatic idle_bus();
        apply_stimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'd0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        apply_stimulus(1'b1, 1'b0, 1'b1, a, d);
        step(1);
        idle_bus();
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] v);
        apply_stimulus(1'b1, 1'b1, 1'b0, a, 32'd0);
        @(negedge clk);
        v = readdata;
        step(1);
        idle_bus();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            step(1);
            n++;
        end
        check_output("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin : stimulus
        logic [31:0] v;
        int          q [$];

        model_reset();
        idle_bus();
        reset_n = 1'b0;
        step(2);
        address = 3'd1;
        #1;
        check_output("rst_sel", {27'd0, sel_out}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_status", readdata, 32'd0);
        idle_bus();
        reset_n = 1'b1;
        step(1);
        read_reg(3'd2, v); check_output("rst_manual", v, 32'd0);
        read_reg(3'd3, v); check_output("rst_rdindex", v, 32'd0);

        $display("[TB] scan 2..4 with S=1");
        write_reg(3'd0, 32'(1 | (2 << 5) | (4 << 10) | (1 << 16)));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) q.push_back(int'(sel_out));
        end
        step(1);
        check_output("busy_len", 32'(q.size()), 32'd9);
        for (int i = 0; i < 9; i++) check_output("sel_seq", (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
        read_reg(3'd1, v); check_output("status_done", v, 32'h2);
        write_reg(3'd3, 32'd2);
        read_reg(3'd4, v); check_output("buf2", v, 32'hA2);
        read_reg(3'd4, v); check_output("buf3", v, 32'hA3);
        read_reg(3'd4, v); check_output("buf4", v, 32'hA4);

        $display("[TB] first > last");
        write_reg(3'd0, 32'(1 | (5 << 5) | (3 << 10)));
        step(4);
        read_reg(3'd1, v); check_output("status_err", v, 32'h6);
        write_reg(3'd1, 32'h4);
        read_reg(3'd1, v); check_output("err_clear", v, 32'h2);
        write_reg(3'd1, 32'h2);
        read_reg(3'd1, v); check_output("done_clear", v, 32'h0);

        $display("[TB] full scan with abort");
        write_reg(3'd0, 32'(1 | (31 << 10)));
        write_reg(3'd2, 32'd7);
        check_output("sel_midscan", {27'd0, sel_out}, 32'd0);
        step(8);
        write_reg(3'd0, 32'h2);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_sel", {27'd0, sel_out}, 32'd7);
        read_reg(3'd1, v); check_output("abort_status", v, 32'h0);

        $display("[TB] read index wrap");
        write_reg(3'd0, 32'(1 | (30 << 5) | (31 << 10)));
        wait_idle(20);
        write_reg(3'd3, 32'd31);
        read_reg(3'd4, v); check_output("buf31", v, 32'hBF);
        read_reg(3'd4, v); check_output("buf0_wrap", v, 32'hA0);
        read_reg(3'd3, v); check_output("rdindex_wrap", v, 32'd1);

        $display("[TB] done set wins over clear");
        write_reg(3'd0, 32'(1 | (6 << 5) | (6 << 10) | (1 << 20)));
        step(1);
        write_reg(3'd1, 32'h2);
        read_reg(3'd1, v); check_output("done_set_wins", v, 32'h2);
        check_output("irq_set", {31'd0, irq}, {31'd0, IRQ_BUILD});
        write_reg(3'd1, 32'h2);
        read_reg(3'd1, v); check_output("done_cleared", v, 32'h0);
        check_output("irq_clear", {31'd0, irq}, 32'd0);

        $display("[TB] reset mid-settle");
        write_reg(3'd2, 32'd9);
        write_reg(3'd0, 32'(1 | (3 << 10) | (15 << 16)));
        step(3);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3'd1, 32'd0);
        #1;
        check_output("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_output("async_sel", {27'd0, sel_out}, 32'd0);
        check_output("async_busy", {31'd0, busy}, 32'd0);
        check_output("async_status", readdata, 32'd0);
        check_output("async_irq", {31'd0, irq}, 32'd0);
        idle_bus();
        step(2);
        reset_n = 1'b1;
        step(1);
        read_reg(3'd2, v); check_output("post_rst_manual", v, 32'd0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
